// File: rtl/icache_ctrl.sv
// ---------------------------------------------------------------------------
// icache_ctrl
//   Direct-mapped, read-only instruction cache between the core's fetch port
//   and the instruction ROM. Hits are answered combinationally. A miss stalls
//   the core while the whole line is refilled from offset 0, one word per
//   accepted ROM beat. The ROM may hold off any beat with mem_miss. A one-cycle
//   flush invalidates every line and aborts a refill that is in progress.
//
// Ports
//   Clk       in   system clock, rising edge
//   Rst       in   asynchronous reset, active low
//   cpu_req   in   fetch request valid
//   cpu_addr  in   fetch word address
//   cpu_data  out  fetched instruction (0 unless hit)
//   cpu_miss  out  stall; cpu_data is not valid while high
//   flush     in   invalidate all lines
//   mem_en    out  ROM read enable
//   mem_addr  out  ROM word address
//   mem_data  in   ROM read data
//   mem_miss  in   ROM not ready; mem_data invalid this cycle
// ---------------------------------------------------------------------------
module icache_ctrl #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_BITS  = 4,
   parameter int OFFSET_BITS = 2
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  cpu_req,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   output logic [DATA_WIDTH-1:0] cpu_data,
   output logic                  cpu_miss,
   input  logic                  flush,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  mem_miss
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = 1 << OFFSET_BITS;
   localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REFILL    = 2'd1,
      FILL_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // line storage; only the valid bits need reset
   logic [LINES-1:0]      valid_q;
   logic [TAG_BITS-1:0]   tag_q  [LINES];
   logic [DATA_WIDTH-1:0] data_q [LINES][WORDS];
   logic [OFFSET_BITS-1:0] beat_q;

   // lookup address fields
   logic [OFFSET_BITS-1:0] req_off;
   logic [INDEX_BITS-1:0]  req_idx;
   logic [TAG_BITS-1:0]    req_tag;

   // the line being refilled lives in the upper bits of mem_addr, which stay
   // frozen for the whole refill since only the offset field increments
   logic [INDEX_BITS-1:0]  fill_idx;
   logic [TAG_BITS-1:0]    fill_tag;

   logic hit;
   logic beat_ok;
   logic last_beat;
   logic start_fill;

   assign req_off  = cpu_addr[OFFSET_BITS-1:0];
   assign req_idx  = cpu_addr[OFFSET_BITS +: INDEX_BITS];
   assign req_tag  = cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
   assign fill_idx = mem_addr[OFFSET_BITS +: INDEX_BITS];
   assign fill_tag = mem_addr[ADDR_WIDTH-1 -: TAG_BITS];

   // ------------------------------------------------------------------------
   // lookup
   // ------------------------------------------------------------------------
   assign hit      = cpu_req & valid_q[req_idx] & (tag_q[req_idx] == req_tag)
                   & (state_q == IDLE);
   assign cpu_miss = cpu_req & ~hit;
   assign cpu_data = hit ? data_q[req_idx][req_off] : '0;

   // flush has priority over a miss seen in the same IDLE cycle
   assign start_fill = (state_q == IDLE) & cpu_miss & ~flush;
   assign beat_ok    = (state_q == REFILL) & mem_en & ~mem_miss;
   assign last_beat  = beat_ok & (beat_q == OFFSET_BITS'(WORDS - 1));

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (start_fill) state_d = REFILL;
         REFILL: begin
            if (flush)          state_d = IDLE;
            else if (last_beat) state_d = FILL_DONE;
         end
         FILL_DONE: state_d = IDLE;   // re-look-up whatever cpu_addr is now
         default:   state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // control registers
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         valid_q  <= '0;
         mem_en   <= 1'b0;
         mem_addr <= '0;
         beat_q   <= '0;
      end else begin
         // valid drops at refill start so a victim line is never half-valid;
         // a flush in the final beat cycle wins over validation
         if (flush)
            valid_q <= '0;
         else if (start_fill)
            valid_q[req_idx] <= 1'b0;
         else if (last_beat)
            valid_q[fill_idx] <= 1'b1;

         if (start_fill) begin
            mem_addr <= {cpu_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            mem_en   <= 1'b1;
            beat_q   <= '0;
         end else if (state_q == REFILL) begin
            if (flush) begin
               mem_en <= 1'b0;
            end else if (beat_ok) begin
               beat_q                       <= beat_q + 1'b1;
               mem_addr[OFFSET_BITS-1:0]    <= mem_addr[OFFSET_BITS-1:0] + 1'b1;
               if (last_beat) mem_en        <= 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // tag / data arrays (no reset; guarded by valid_q)
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (beat_ok && !flush) begin
         data_q[fill_idx][beat_q] <= mem_data;
         if (last_beat) tag_q[fill_idx] <= fill_tag;
      end
   end

endmodule

// File: tb/tb_icache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_icache_ctrl
//   Self-checking bench for icache_ctrl. The ROM returns addr+0x100 on every
//   ready beat and a poison word while mem_miss is high. A reference model
//   tracks which (index, tag) pairs are resident and predicts, per fetch, the
//   ordered ROM addresses, the stall length and the returned instruction.
// ---------------------------------------------------------------------------
module tb_icache_ctrl;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_data;
   logic        cpu_miss;
   logic        flush = 1'b0;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_miss = 1'b0;

   int tests_run = 0;
   int fails     = 0;

   // reference model: which tag each index holds, if any
   bit          mvalid [16];
   logic [25:0] mtag   [16];
   logic [31:0] exp_q  [$];

   always #5 Clk = ~Clk;

   assign mem_data = mem_miss ? 32'hBAD0_0000 : mem_addr + 32'h100;

   icache_ctrl dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .cpu_req  (cpu_req),
      .cpu_addr (cpu_addr),
      .cpu_data (cpu_data),
      .cpu_miss (cpu_miss),
      .flush    (flush),
      .mem_en   (mem_en),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_miss (mem_miss)
   );

   function automatic bit m_hit(input logic [31:0] a);
      return mvalid[a[5:2]] && (mtag[a[5:2]] == a[31:6]);
   endfunction

   function automatic void m_fill(input logic [31:0] a);
      mvalid[a[5:2]] = 1'b1;
      mtag[a[5:2]]   = a[31:6];
   endfunction

   function automatic void m_clear();
      for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
   endfunction

   // Issue a fetch of 'a' (switching cpu_addr to 'a2' after 'sw' stall cycles
   // when sw > 0) and hold it until served. ROM wait: either 'wlen' wait
   // cycles on beat 'wbeat', or a random wait with probability wpct percent.
   // Called and returns at posedge+1.
   task automatic run_fetch(input logic [31:0] a, input logic [31:0] a2,
                            input int sw, input int wbeat, input int wlen,
                            input int wpct, output int stalls);
      logic [31:0] fa;
      int acc, held, waits, exp_stall;
      exp_q.delete();
      fa = (sw > 0) ? a2 : a;
      if (!m_hit(a)) begin
         for (int k = 0; k < 4; k++) exp_q.push_back({a[31:2], 2'b00} + 32'(k));
         m_fill(a);
      end
      if (!m_hit(fa)) begin
         for (int k = 0; k < 4; k++) exp_q.push_back({fa[31:2], 2'b00} + 32'(k));
         m_fill(fa);
      end
      exp_stall = 6 * (exp_q.size() / 4);
      cpu_req = 1'b1; cpu_addr = a;
      stalls = 0; acc = 0; held = 0; waits = 0;
      forever begin
         if (sw > 0 && stalls == sw) cpu_addr = a2;
         if (wlen > 0) mem_miss = (acc == wbeat) && (held < wlen);
         else          mem_miss = (wpct > 0) && (int'($urandom_range(99)) < wpct);
         #1;
         if (mem_en) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL mem_addr_extra: got %h, expected no ROM read", mem_addr);
            end else if (mem_addr !== exp_q[0]) begin
               fails++;
               $display("FAIL mem_addr_seq: got %h, expected %h", mem_addr, exp_q[0]);
            end
            if (mem_miss) begin held++; waits++; end
            else if (exp_q.size() != 0) begin void'(exp_q.pop_front()); acc++; end
         end
         if (!cpu_miss || stalls >= 100) break;
         stalls++;
         @(posedge Clk); #1;
      end
      tests_run++;
      if (cpu_miss !== 1'b0) begin
         fails++;
         $display("FAIL fetch_timeout: addr %h still stalled after %0d cycles", fa, stalls);
      end
      tests_run++;
      if (stalls != exp_stall + waits) begin
         fails++;
         $display("FAIL stall_len: addr %h got %0d, expected %0d", fa, stalls, exp_stall + waits);
      end
      tests_run++;
      if (cpu_data !== fa + 32'h100) begin
         fails++;
         $display("FAIL cpu_data: addr %h got %h, expected %h", fa, cpu_data, fa + 32'h100);
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL refill_beats: %0d beats missing, expected 0", exp_q.size());
      end
      mem_miss = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic do_flush();
      cpu_req = 1'b0; flush = 1'b1;
      @(posedge Clk); #1;
      flush = 1'b0;
      m_clear();
   endtask

   task automatic test_reset();
      cpu_req = 1'b0; Rst = 1'b0;
      #12;
      tests_run++;
      if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin
         fails++;
         $display("FAIL reset_mem: got en=%b addr=%h, expected en=0 addr=0", mem_en, mem_addr);
      end
      tests_run++;
      if (cpu_miss !== 1'b0 || cpu_data !== 32'h0) begin
         fails++;
         $display("FAIL reset_idle_cpu: got miss=%b data=%h, expected 0/0", cpu_miss, cpu_data);
      end
      cpu_req = 1'b1; cpu_addr = 32'h10; #1;
      tests_run++;
      if (cpu_miss !== 1'b1 || cpu_data !== 32'h0) begin
         fails++;
         $display("FAIL reset_req_miss: got miss=%b data=%h, expected 1/0", cpu_miss, cpu_data);
      end
      cpu_req = 1'b0;
      m_clear();
      @(negedge Clk); Rst = 1'b1;
      @(posedge Clk); #1;
   endtask

   task automatic test_basic_miss();
      int st;
      run_fetch(32'h10, 32'h0, 0, 0, 0, 0, st);
      tests_run++;
      if (st != 6) begin
         fails++;
         $display("FAIL basic_stall: got %0d, expected 6", st);
      end
      for (int k = 1; k < 4; k++) begin
         run_fetch(32'h10 + 32'(k), 32'h0, 0, 0, 0, 0, st);
         tests_run++;
         if (st != 0) begin
            fails++;
            $display("FAIL line_hit: offset %0d got %0d stalls, expected 0", k, st);
         end
      end
   endtask

   task automatic test_wait_states();
      int st;
      do_flush();
      run_fetch(32'h10, 32'h0, 0, 2, 3, 0, st);
      tests_run++;
      if (st != 9) begin
         fails++;
         $display("FAIL wait_stall: got %0d, expected 9", st);
      end
   endtask

   task automatic test_eviction();
      int st;
      run_fetch(32'h10, 32'h0, 0, 0, 0, 0, st);
      run_fetch(32'h50, 32'h0, 0, 0, 0, 0, st);
      run_fetch(32'h10, 32'h0, 0, 0, 0, 0, st);
      tests_run++;
      if (st != 6) begin
         fails++;
         $display("FAIL evict_refetch: got %0d stalls, expected 6", st);
      end
   endtask

   task automatic test_flush();
      int st;
      do_flush();
      run_fetch(32'h24, 32'h0, 0, 0, 0, 0, st);
      cpu_req = 1'b1; cpu_addr = 32'h10; mem_miss = 1'b0;
      @(posedge Clk); #1;        // REFILL, beat 0
      @(posedge Clk); #1;        // beat 1
      tests_run++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h11) begin
         fails++;
         $display("FAIL flush_setup: got en=%b addr=%h, expected 1/00000011", mem_en, mem_addr);
      end
      flush = 1'b1;
      @(posedge Clk); #1;
      flush = 1'b0;
      m_clear();
      tests_run++;
      if (mem_en !== 1'b0 || cpu_miss !== 1'b1) begin
         fails++;
         $display("FAIL flush_abort: got en=%b miss=%b, expected 0/1", mem_en, cpu_miss);
      end
      run_fetch(32'h10, 32'h0, 0, 0, 0, 0, st);
      tests_run++;
      if (st != 6) begin
         fails++;
         $display("FAIL flush_refill: got %0d stalls, expected 6", st);
      end
      run_fetch(32'h24, 32'h0, 0, 0, 0, 0, st);
      // flush and miss in the same IDLE cycle
      cpu_req = 1'b1; cpu_addr = 32'h38; flush = 1'b1; #1;
      tests_run++;
      if (cpu_miss !== 1'b1) begin
         fails++;
         $display("FAIL flush_miss_same: got miss=%b, expected 1", cpu_miss);
      end
      @(posedge Clk); #1;
      flush = 1'b0;
      m_clear();
      tests_run++;
      if (mem_en !== 1'b0) begin
         fails++;
         $display("FAIL flush_wins: got en=%b, expected 0", mem_en);
      end
      run_fetch(32'h38, 32'h0, 0, 0, 0, 0, st);
      run_fetch(32'h10, 32'h0, 0, 0, 0, 0, st);
   endtask

   task automatic test_reset_mid_refill();
      int st;
      cpu_req = 1'b1; cpu_addr = 32'h30; mem_miss = 1'b0;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      #2 Rst = 1'b0;
      #1;
      tests_run++;
      if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin
         fails++;
         $display("FAIL async_reset: got en=%b addr=%h, expected 0/0", mem_en, mem_addr);
      end
      cpu_req = 1'b0;
      m_clear();
      @(negedge Clk); Rst = 1'b1;
      @(posedge Clk); #1;
      run_fetch(32'h30, 32'h0, 0, 0, 0, 0, st);
      tests_run++;
      if (st != 6) begin
         fails++;
         $display("FAIL post_reset_miss: got %0d stalls, expected 6", st);
      end
   endtask

   task automatic test_addr_switch();
      int st;
      do_flush();
      run_fetch(32'h10, 32'h24, 2, 0, 0, 0, st);
      tests_run++;
      if (st != 12) begin
         fails++;
         $display("FAIL switch_stall: got %0d, expected 12", st);
      end
      run_fetch(32'h10, 32'h0, 0, 0, 0, 0, st);
      tests_run++;
      if (st != 0) begin
         fails++;
         $display("FAIL switch_old_hit: got %0d stalls, expected 0", st);
      end
   endtask

   task automatic test_random();
      int st;
      logic [31:0] a;
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(19) == 0) do_flush();
         if ($urandom_range(9) == 0) begin
            cpu_req = 1'b0; cpu_addr = $urandom; #1;
            tests_run++;
            if (cpu_miss !== 1'b0 || cpu_data !== 32'h0) begin
               fails++;
               $display("FAIL idle_outputs: got miss=%b data=%h, expected 0/0", cpu_miss, cpu_data);
            end
            @(posedge Clk); #1;
         end
         a = {24'h0, 2'(int'($urandom_range(2))), 4'($urandom_range(15)), 2'($urandom_range(3))};
         if (n % 3 == 0) a[31:28] = 4'($urandom_range(15));
         run_fetch(a, 32'h0, 0, 0, 0, 30, st);
      end
   endtask

   initial begin
      m_clear();
      test_reset();
      test_basic_miss();
      test_wait_states();
      test_eviction();
      test_flush();
      test_reset_mid_refill();
      test_addr_switch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
